jpeg_dezigzag_buf: RTL and testbench



---
 rtl/jpeg_dezigzag_buf_if.sv | 26 ++
 rtl/jpeg_dezigzag_buf.sv | 143 ++++++++++++++
 tb/tb_jpeg_dezigzag_buf.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/jpeg_dezigzag_buf_if.sv
// Handshake bundle for the inverse-zigzag buffer: a zigzag-ordered coefficient
// stream in, a raster-ordered coefficient stream out with its raster index.
interface jpeg_dezigzag_buf_if #(
  parameter int DW = 12
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [5:0]    out_idx;
  logic          out_last;

  // Upstream/downstream side: produces coefficients and consumes the reordered stream.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last
  );

  // Buffer side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last
  );
endinterface

// File: rtl/jpeg_dezigzag_buf.sv
// Inverse zigzag reorder buffer. Coefficients arrive in zigzag scan order and
// are scattered into raster position as they are written; the read side then
// streams a full bank out sequentially. Two banks ping-pong so one block can
// fill while the previous one drains.
module jpeg_dezigzag_buf #(
  parameter int DW = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  jpeg_dezigzag_buf_if.slave   bus
);

  // Zigzag scan index -> raster (row*8+col) position.
  function automatic logic [5:0] zz(input logic [5:0] k);
    case (k)
      6'd0:  zz = 6'd0;   6'd1:  zz = 6'd1;   6'd2:  zz = 6'd8;   6'd3:  zz = 6'd16;
      6'd4:  zz = 6'd9;   6'd5:  zz = 6'd2;   6'd6:  zz = 6'd3;   6'd7:  zz = 6'd10;
      6'd8:  zz = 6'd17;  6'd9:  zz = 6'd24;  6'd10: zz = 6'd32;  6'd11: zz = 6'd25;
      6'd12: zz = 6'd18;  6'd13: zz = 6'd11;  6'd14: zz = 6'd4;   6'd15: zz = 6'd5;
      6'd16: zz = 6'd12;  6'd17: zz = 6'd19;  6'd18: zz = 6'd26;  6'd19: zz = 6'd33;
      6'd20: zz = 6'd40;  6'd21: zz = 6'd48;  6'd22: zz = 6'd41;  6'd23: zz = 6'd34;
      6'd24: zz = 6'd27;  6'd25: zz = 6'd20;  6'd26: zz = 6'd13;  6'd27: zz = 6'd6;
      6'd28: zz = 6'd7;   6'd29: zz = 6'd14;  6'd30: zz = 6'd21;  6'd31: zz = 6'd28;
      6'd32: zz = 6'd35;  6'd33: zz = 6'd42;  6'd34: zz = 6'd49;  6'd35: zz = 6'd56;
      6'd36: zz = 6'd57;  6'd37: zz = 6'd50;  6'd38: zz = 6'd43;  6'd39: zz = 6'd36;
      6'd40: zz = 6'd29;  6'd41: zz = 6'd22;  6'd42: zz = 6'd15;  6'd43: zz = 6'd23;
      6'd44: zz = 6'd30;  6'd45: zz = 6'd37;  6'd46: zz = 6'd44;  6'd47: zz = 6'd51;
      6'd48: zz = 6'd58;  6'd49: zz = 6'd59;  6'd50: zz = 6'd52;  6'd51: zz = 6'd45;
      6'd52: zz = 6'd38;  6'd53: zz = 6'd31;  6'd54: zz = 6'd39;  6'd55: zz = 6'd46;
      6'd56: zz = 6'd53;  6'd57: zz = 6'd60;  6'd58: zz = 6'd61;  6'd59: zz = 6'd54;
      6'd60: zz = 6'd47;  6'd61: zz = 6'd55;  6'd62: zz = 6'd62;  6'd63: zz = 6'd63;
      default: zz = 6'd0;
    endcase
  endfunction

  logic [DW-1:0] bank_q [2][64];

  logic [1:0]    full_q,  full_d;
  logic          wbank_q, wbank_d;
  logic [5:0]    wcnt_q,  wcnt_d;
  logic          rbank_q, rbank_d;
  logic [5:0]    rcnt_q,  rcnt_d;

  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q,  out_data_d;
  logic [5:0]    out_idx_q,   out_idx_d;
  logic          out_last_q,  out_last_d;

  logic          in_ready_s;
  logic          wr_fire_s;
  logic          load_s;

  // Next-state logic for both bank pointers, fill flags and the output register.
  always_comb begin
    in_ready_s  = !full_q[wbank_q];
    wr_fire_s   = bus.in_valid && in_ready_s;
    load_s      = full_q[rbank_q] && (!out_valid_q || bus.out_ready);

    full_d      = full_q;
    wbank_d     = wbank_q;
    wcnt_d      = wcnt_q;
    rbank_d     = rbank_q;
    rcnt_d      = rcnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;

    // Write side: the 6-bit count wraps on its own after the 64th coefficient.
    if (wr_fire_s) begin
      wcnt_d = wcnt_q + 6'd1;
      if (wcnt_q == 6'd63) begin
        full_d[wbank_q] = 1'b1;
        wbank_d         = !wbank_q;
      end else begin
        wbank_d         = wbank_q;
      end
    end else begin
      wcnt_d = wcnt_q;
    end

    // Read side: the write bank is never full, so the set above and the clear
    // below always target different banks and both take effect.
    if (load_s) begin
      out_valid_d = 1'b1;
      out_data_d  = bank_q[rbank_q][rcnt_q];
      out_idx_d   = rcnt_q;
      out_last_d  = (rcnt_q == 6'd63);
      rcnt_d      = rcnt_q + 6'd1;
      if (rcnt_q == 6'd63) begin
        full_d[rbank_q] = 1'b0;
        rbank_d         = !rbank_q;
      end else begin
        rbank_d         = rbank_q;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Control state and output register; reset empties both banks logically.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q      <= 2'b00;
      wbank_q     <= 1'b0;
      wcnt_q      <= 6'd0;
      rbank_q     <= 1'b0;
      rcnt_q      <= 6'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= 6'd0;
      out_last_q  <= 1'b0;
    end else begin
      full_q      <= full_d;
      wbank_q     <= wbank_d;
      wcnt_q      <= wcnt_d;
      rbank_q     <= rbank_d;
      rcnt_q      <= rcnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
    end
  end

  // Coefficient storage, scattered to raster position on write. No reset:
  // contents are only ever read from a bank whose full flag was set by a
  // complete post-reset fill.
  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      bank_q[wbank_q][zz(wcnt_q)] <= bus.in_data;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_jpeg_dezigzag_buf.sv
// Directed bench for jpeg_dezigzag_buf: each task drives one scenario and
// checks the reordered stream against an expected raster ordering.
module tb_jpeg_dezigzag_buf;

  logic clk = 1'b0;
  logic rst_n;

  jpeg_dezigzag_buf_if #(.DW(12)) bus ();

  jpeg_dezigzag_buf #(.DW(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Standard JPEG zigzag map: entry k is the raster position of scan index k.
  int zz_tab [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};
  int inv_tab [64];
  int head_exp [8] = '{0, 1, 5, 6, 14, 15, 27, 28};
  int tail_exp [8] = '{35, 36, 48, 49, 57, 58, 62, 63};

  logic        o_valid, o_in_ready, o_last;
  logic [11:0] o_data;
  logic [5:0]  o_idx;
  logic        in_fire, out_fire;

  // Drive one cycle's inputs at the falling edge and capture the outputs the
  // DUT presents for the next rising edge.
  task automatic step(input logic iv, input int d, input logic ordy);
    @(negedge clk);
    bus.in_valid  = iv;
    bus.in_data   = d[11:0];
    bus.out_ready = ordy;
    o_valid    = bus.out_valid;
    o_in_ready = bus.in_ready;
    o_data     = bus.out_data;
    o_idx      = bus.out_idx;
    o_last     = bus.out_last;
    in_fire    = iv && bus.in_ready;
    out_fire   = bus.out_valid && ordy;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_data = 12'd0; bus.out_ready = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
    total++; if (bus.out_data !== 12'd0) begin bad++; $display("FAIL reset_out_data got=%0h exp=0", bus.out_data); end
    total++; if (bus.out_idx !== 6'd0) begin bad++; $display("FAIL reset_out_idx got=%0d exp=0", bus.out_idx); end
    total++; if (bus.out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%0b exp=0", bus.out_last); end
  endtask

  task automatic test_single_block();
    int exp_v;
    for (int k = 0; k < 64; k++) begin
      step(1'b1, k, 1'b1);
      total++; if (in_fire !== 1'b1) begin bad++; $display("FAIL single_accept k=%0d got=%0b exp=1", k, in_fire); end
    end
    step(1'b0, 0, 1'b1);
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL single_latency_early got=%0b exp=0", o_valid); end
    for (int r = 0; r < 64; r++) begin
      step(1'b0, 0, 1'b1);
      if (r < 8) exp_v = head_exp[r];
      else if (r >= 56) exp_v = tail_exp[r-56];
      else exp_v = inv_tab[r];
      total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL single_valid r=%0d got=%0b exp=1", r, o_valid); end
      total++; if (o_idx !== 6'(r)) begin bad++; $display("FAIL single_idx got=%0d exp=%0d", o_idx, r); end
      total++; if (o_data !== 12'(exp_v)) begin bad++; $display("FAIL single_data r=%0d got=%0d exp=%0d", r, o_data, exp_v); end
      total++; if (o_last !== (r == 63)) begin bad++; $display("FAIL single_last r=%0d got=%0b exp=%0b", r, o_last, (r == 63)); end
    end
    step(1'b0, 0, 1'b1);
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL single_valid_end got=%0b exp=0", o_valid); end
  endtask

  task automatic test_back_to_back();
    int sent = 0; int recv = 0; int exp_v; logic started = 1'b0;
    for (int cyc = 0; cyc < 400 && recv < 192; cyc++) begin
      step(sent < 192, 1000 + sent, 1'b1);
      if (sent < 192) begin
        total++; if (o_in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready cyc=%0d got=%0b exp=1", cyc, o_in_ready); end
      end
      if (started) begin
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL b2b_contiguous recv=%0d got=%0b exp=1", recv, o_valid); end
      end
      if (out_fire) begin
        started = 1'b1;
        exp_v = 1000 + (recv / 64) * 64 + inv_tab[recv % 64];
        total++; if (o_data !== 12'(exp_v) || o_idx !== 6'(recv % 64) || o_last !== (recv % 64 == 63)) begin
          bad++; $display("FAIL b2b_out recv=%0d got=%0d/%0d/%0b exp=%0d/%0d", recv, o_data, o_idx, o_last, exp_v, recv % 64);
        end
        recv++;
      end
      if (in_fire) sent++;
    end
    total++; if (recv != 192) begin bad++; $display("FAIL b2b_count got=%0d exp=192", recv); end
  endtask

  task automatic test_backpressure();
    int sent = 0; int recv = 0; int exp_v; logic just_full = 1'b0;
    for (int cyc = 0; cyc < 140; cyc++) begin
      step(1'b1, 2000 + sent, 1'b0);
      if (just_full) begin
        total++; if (o_in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_drop got=%0b exp=0", o_in_ready); end
        just_full = 1'b0;
      end
      if (in_fire) begin
        sent++;
        if (sent == 128) just_full = 1'b1;
      end
    end
    total++; if (sent != 128) begin bad++; $display("FAIL bp_accepted got=%0d exp=128", sent); end
    total++; if (o_in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%0b exp=0", o_in_ready); end
    total++; if (o_valid !== 1'b1 || o_idx !== 6'd0 || o_data !== 12'd2000 || o_last !== 1'b0) begin
      bad++; $display("FAIL bp_hold got=%0b/%0d/%0d exp=1/0/2000", o_valid, o_idx, o_data);
    end
    for (int cyc = 0; cyc < 500 && recv < 192; cyc++) begin
      step(sent < 192, 2000 + sent, 1'b1);
      if (out_fire) begin
        exp_v = 2000 + (recv / 64) * 64 + inv_tab[recv % 64];
        total++; if (o_data !== 12'(exp_v) || o_idx !== 6'(recv % 64)) begin
          bad++; $display("FAIL bp_drain recv=%0d got=%0d/%0d exp=%0d/%0d", recv, o_data, o_idx, exp_v, recv % 64);
        end
        recv++;
      end
      if (in_fire) sent++;
    end
    total++; if (recv != 192 || sent != 192) begin bad++; $display("FAIL bp_total got=%0d/%0d exp=192/192", recv, sent); end
  endtask

  task automatic test_random();
    int sent = 0; int recv = 0; int exp_v;
    logic iv, ordy, pv = 1'b0, pr = 1'b1, pl = 1'b0;
    logic [11:0] pd = 12'd0; logic [5:0] pi = 6'd0;
    for (int cyc = 0; cyc < 6000 && recv < 640; cyc++) begin
      iv   = (sent < 640) && ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 1) == 1);
      step(iv, 3000 + sent, ordy);
      if (pv && !pr) begin
        total++; if ({o_valid, o_data, o_idx, o_last} !== {1'b1, pd, pi, pl}) begin
          bad++; $display("FAIL rnd_stall got=%0b/%0d/%0d exp=1/%0d/%0d", o_valid, o_data, o_idx, pd, pi);
        end
      end
      if (out_fire) begin
        exp_v = 3000 + (recv / 64) * 64 + inv_tab[recv % 64];
        total++; if (o_data !== 12'(exp_v) || o_idx !== 6'(recv % 64) || o_last !== (recv % 64 == 63)) begin
          bad++; $display("FAIL rnd_out recv=%0d got=%0d/%0d/%0b exp=%0d/%0d", recv, o_data, o_idx, o_last, exp_v, recv % 64);
        end
        recv++;
      end
      if (in_fire) sent++;
      pv = o_valid; pr = ordy; pd = o_data; pi = o_idx; pl = o_last;
    end
    total++; if (recv != 640) begin bad++; $display("FAIL rnd_count got=%0d exp=640", recv); end
  endtask

  task automatic test_reset_mid_fill();
    int sent = 0; int recv = 0; int exp_v;
    for (int k = 0; k < 30; k++) step(1'b1, 100 + k, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    total++; if ({bus.in_ready, bus.out_valid, bus.out_data, bus.out_idx, bus.out_last} !== {1'b1, 1'b0, 12'd0, 6'd0, 1'b0}) begin
      bad++; $display("FAIL rst_fill_outputs got=%0b/%0b/%0d/%0d/%0b exp=1/0/0/0/0", bus.in_ready, bus.out_valid, bus.out_data, bus.out_idx, bus.out_last);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 300 && recv < 64; cyc++) begin
      step(sent < 64, 500 + sent, 1'b1);
      if (sent < 64) begin
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_fill_stale sent=%0d got=%0b exp=0", sent, o_valid); end
      end
      if (out_fire) begin
        exp_v = 500 + inv_tab[recv];
        total++; if (o_data !== 12'(exp_v) || o_idx !== 6'(recv)) begin
          bad++; $display("FAIL rst_fill_out recv=%0d got=%0d/%0d exp=%0d/%0d", recv, o_data, o_idx, exp_v, recv);
        end
        recv++;
      end
      if (in_fire) sent++;
    end
    total++; if (recv != 64) begin bad++; $display("FAIL rst_fill_count got=%0d exp=64", recv); end
  endtask

  task automatic test_reset_drain();
    int sent = 0; int recv = 0; int exp_v; logic hit = 1'b0;
    for (int cyc = 0; cyc < 140; cyc++) begin
      step(sent < 128, 600 + sent, 1'b0);
      if (in_fire) sent++;
    end
    for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
      step(1'b0, 0, 1'b1);
      if (o_valid && o_idx == 6'd20) hit = 1'b1;
    end
    total++; if (!hit) begin bad++; $display("FAIL rst_drain_reach got=0 exp=1"); end
    #1 rst_n = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.out_idx !== 6'd0 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL rst_drain_outputs got=%0b/%0d/%0b exp=0/0/1", bus.out_valid, bus.out_idx, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      step(1'b0, 0, 1'b1);
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_drain_residue cyc=%0d got=%0b exp=0", cyc, o_valid); end
    end
    sent = 0;
    for (int cyc = 0; cyc < 300 && recv < 64; cyc++) begin
      step(sent < 64, 700 + sent, 1'b1);
      if (out_fire) begin
        exp_v = 700 + inv_tab[recv];
        total++; if (o_data !== 12'(exp_v) || o_idx !== 6'(recv)) begin
          bad++; $display("FAIL rst_drain_new recv=%0d got=%0d/%0d exp=%0d/%0d", recv, o_data, o_idx, exp_v, recv);
        end
        recv++;
      end
      if (in_fire) sent++;
    end
    total++; if (recv != 64) begin bad++; $display("FAIL rst_drain_count got=%0d exp=64", recv); end
  endtask

  initial begin
    for (int k = 0; k < 64; k++) inv_tab[zz_tab[k]] = k;
    test_reset();
    test_single_block();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid_fill();
    test_reset_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
